dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate L1 data-cache controller between the CPU memory stage and the 256-bit-line data SRAM. It owns the tag/valid/dirty arrays and decides hit/miss. It drives the data SRAM's address/enable/write/data lines and sequences line write-back and refill against the off-chip data memory. The CPU sees a single stall signal.

## Interface
- ADDR_W, 32, byte address width
- Line = 256 bits (`DM_UNIT_MASK+1`), offset = 5 bits; index = `L1_INDEX_SIZE` bits; tag = ADDR_W-5-`L1_INDEX_SIZE` bits

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  CPU access valid
- cpu_we_i  in  1  1=store word, 0=load word
- cpu_addr_i  in  ADDR_W  byte address, word aligned
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data
- cpu_stall_o  out  1  request not yet complete
- sram_addr_o  out  `L1_INDEX_SIZE`  data SRAM index
- sram_enable_o  out  1  data SRAM enable
- sram_write_o  out  1  data SRAM write strobe
- sram_data_o  out  256  line to write
- sram_data_i  in  256  line read (combinational)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1=write-back, 0=fill
- mem_addr_o  out  ADDR_W  line address, low 5 bits zero
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fill line
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- States: IDLE, WB (write-back outstanding), FILL (refill outstanding), UPDATE (install line).
- IDLE, no request: all sram/mem enables 0, cpu_stall_o=0.
- IDLE, request: sram_enable_o=1, sram_addr_o=index. Hit = valid[index] && tag[index]==addr tag.
  - Load hit: cpu_rdata_o = word (addr[4:2]) of sram_data_i, same cycle, no stall.
  - Store hit: sram_write_o=1. sram_data_o = sram_data_i with word addr[4:2] replaced. Dirty set at the clock edge. No stall.
  - Miss: cpu_stall_o=1 combinationally. If the victim is valid and dirty, go to WB. Otherwise go to FILL.
- WB: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}. mem_data_o holds the victim line, latched on entry. On mem_ack_i go to FILL.
- FILL: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag,index,5'b0}. On mem_ack_i latch mem_data_i and go to UPDATE.
- UPDATE: write the latched line (with store word merged if cpu_we_i) to SRAM. tag=req tag, valid=1, dirty=cpu_we_i. Go to IDLE. The access then hits the next cycle.
- CPU holds req/we/addr/wdata stable while stalled. cpu_stall_o=1 in WB, FILL, UPDATE.
- mem_enable_o stays high until the ack cycle inclusive, then drops. An ack outside WB/FILL is ignored.

## Timing
- Hit: 0 extra cycles.
- Clean miss: FILL (≥1 cycle until ack), then UPDATE (1), then hit cycle.
- Dirty miss: adds the WB cycles before FILL.
- Reset (async assert): state=IDLE, all valid/dirty=0, latches cleared. All outputs 0: cpu_stall_o=0, cpu_rdata_o=0, mem_*=0, sram_*=0. This includes reset mid-WB/FILL: the outstanding memory request is abandoned and mem_enable_o drops immediately.
- Tag array is registered; tag/valid/dirty update on the posedge ending the hit/UPDATE cycle.
- Index wrap: none; direct mapped, `L1_INDEX_MASK+1` sets.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each counts accesses resolved in IDLE, once per access; the retry hit after UPDATE is not counted.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent. Behaviour is otherwise identical.

## Test plan
- Reset, load 0x100 -> stall; FILL mem_addr_o=0x100; ack with line word0=0xDEADBEEF -> UPDATE, then cpu_rdata_o=0xDEADBEEF, stall 0.
- Store 0x104=0x12345678 after fill -> no stall; reload 0x104 returns 0x12345678, dirty set.
- Dirty conflict load (same index, different tag) -> WB with mem_write_o=1, addr=0x100, data word1=0x12345678; then FILL of the new line.
- Ack delayed 10 cycles -> mem_enable_o held 10 cycles, stall held throughout, single transfer.
- Async reset asserted mid-FILL -> mem_enable_o=0 and stall=0 at once; next access to 0x100 misses (valid cleared).
- DCACHE_STATS_EN: 1 miss then 3 hits -> miss_cnt_o=1, hit_cnt_o=3.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller (tags, hit/miss, refill/write-back sequencing).
// Optional DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o access counters.

`ifndef L1_INDEX_SIZE
`define L1_INDEX_SIZE 4
`endif
`ifndef L1_INDEX_MASK
`define L1_INDEX_MASK ((1 << `L1_INDEX_SIZE) - 1)
`endif
`ifndef DM_UNIT_MASK
`define DM_UNIT_MASK 255
`endif

module dcache_controller #(
    parameter int ADDR_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [31:0]               cpu_wdata_i,
    output logic [31:0]               cpu_rdata_o,
    output logic                      cpu_stall_o,
    output logic [`L1_INDEX_SIZE-1:0] sram_addr_o,
    output logic                      sram_enable_o,
    output logic                      sram_write_o,
    output logic [255:0]              sram_data_o,
    input  logic [255:0]              sram_data_i,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [255:0]              mem_data_o,
    input  logic [255:0]              mem_data_i,
    input  logic                      mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o
`endif
);

    localparam int IDX_W  = `L1_INDEX_SIZE;
    localparam int SETS   = `L1_INDEX_MASK + 1;
    localparam int LINE_W = `DM_UNIT_MASK + 1;
    localparam int TAG_W  = ADDR_W - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_UPDATE
    } state_e;

    state_e state_q, state_d;

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [LINE_W-1:0] victim_q;
    logic [LINE_W-1:0] fill_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word_sel;
    logic             hit;
    logic             victim_dirty;
    logic             unused_addr_bits;

    assign idx              = cpu_addr_i[5 +: IDX_W];
    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel         = cpu_addr_i[4:2];
    assign hit              = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty     = valid_q[idx] && dirty_q[idx];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [2:0]        sel,
                                                     input logic [31:0]       data);
        logic [LINE_W-1:0] res;
        res              = line;
        res[sel*32 +: 32] = data;
        return res;
    endfunction

    // Outputs are gated by rst_n_i so that everything reads zero for the whole reset window,
    // even while the CPU keeps presenting a request.
    always_comb begin
        state_d       = state_q;
        cpu_rdata_o   = '0;
        cpu_stall_o   = 1'b0;
        sram_addr_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        if (rst_n_i) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        sram_enable_o = 1'b1;
                        sram_addr_o   = idx;
                        if (hit) begin
                            if (cpu_we_i) begin
                                sram_write_o = 1'b1;
                                sram_data_o  = merge_word(sram_data_i, word_sel, cpu_wdata_i);
                            end else begin
                                cpu_rdata_o = sram_data_i[word_sel*32 +: 32];
                            end
                        end else begin
                            cpu_stall_o = 1'b1;
                            state_d     = victim_dirty ? S_WB : S_FILL;
                        end
                    end
                end
                S_WB: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {tag_q[idx], idx, 5'b0};
                    mem_data_o   = victim_q;
                    if (mem_ack_i) state_d = S_FILL;
                end
                S_FILL: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {req_tag, idx, 5'b0};
                    if (mem_ack_i) state_d = S_UPDATE;
                end
                S_UPDATE: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_addr_o   = idx;
                    sram_data_o   = cpu_we_i ? merge_word(fill_q, word_sel, cpu_wdata_i) : fill_q;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            victim_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < SETS; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        if (hit) begin
                            if (cpu_we_i) dirty_q[idx] <= 1'b1;
                        end else if (victim_dirty) begin
                            // The victim is read out during the miss cycle, before the refill overwrites it.
                            victim_q <= sram_data_i;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack_i) fill_q <= mem_data_i;
                end
                S_UPDATE: begin
                    tag_q[idx]   <= req_tag;
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= cpu_we_i;
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // retry_q marks the guaranteed hit that follows UPDATE; that access was already counted as a miss.
    logic        retry_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retry_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            retry_q <= (state_q == S_UPDATE);
            if (state_q == S_IDLE && cpu_req_i) begin
                if (!hit) miss_cnt_q <= miss_cnt_q + 32'd1;
                else if (!retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: SRAM/memory environment, flat architectural memory model and
// an abstract tag-state model, randomized loads/stores with random memory latencies.

`ifndef L1_INDEX_SIZE
`define L1_INDEX_SIZE 4
`endif
`ifndef L1_INDEX_MASK
`define L1_INDEX_MASK ((1 << `L1_INDEX_SIZE) - 1)
`endif

module tb_dcache_controller;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = `L1_INDEX_SIZE;
  localparam int SETS   = `L1_INDEX_MASK + 1;
  localparam int TAG_W  = ADDR_W - 5 - IDX_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0]       cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;
  logic [IDX_W-1:0]  sram_addr_o;
  logic              sram_enable_o, sram_write_o;
  logic [255:0]      sram_data_o, sram_data_i;
  logic              mem_enable_o, mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [255:0]      mem_data_o;
  logic [255:0]      mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  dcache_controller #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  // clock / data SRAM environment
  always #5 clk = ~clk;

  logic [255:0] sram_mem [SETS];
  assign sram_data_i = sram_mem[sram_addr_o];
  always @(posedge clk) if (sram_enable_o && sram_write_o) sram_mem[sram_addr_o] <= sram_data_o;

  // scoreboard / reference model
  int checks = 0;
  int failures = 0;
  logic [31:0]      exp_q[$];
  logic [31:0]      arch [logic [31:0]];
  logic [255:0]     offmem [logic [31:0]];
  bit               m_valid [SETS];
  bit               m_dirty [SETS];
  logic [TAG_W-1:0] m_tag [SETS];
  int               exp_hits = 0;
  int               exp_misses = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0]  la;
    logic [255:0] l;
    la = {a[31:5], 5'b0};
    if (offmem.exists(la)) begin
      l = offmem[la];
      return l[a[4:2]*32 +: 32];
    end
    return init_word(a);
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return mem_word(a);
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(la + 32'(w * 4));
    return l;
  endfunction

  // A reset loses dirty cache contents, so the architectural view falls back to memory.
  task automatic model_reset();
    logic [31:0] la;
    for (int s = 0; s < SETS; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        la = {m_tag[s], IDX_W'(s), 5'b0};
        for (int w = 0; w < 8; w++) arch[la + 32'(w * 4)] = mem_word(la + 32'(w * 4));
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // driver tasks
  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, cpu_stall_o, 1'b0);
    check_val({tag, "_rdata"}, cpu_rdata_o, 32'h0);
    check_val({tag, "_sram"}, {sram_enable_o, sram_write_o, sram_addr_o, sram_data_o}, '0);
    check_val({tag, "_mem"}, {mem_enable_o, mem_write_o, mem_addr_o}, '0);
    check_val({tag, "_memdata"}, mem_data_o, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ack_i = 1'b0;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h100;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    cpu_req_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic mem_phase(input bit wb, input logic [31:0] la, input logic [255:0] line, input int dly);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      #1;
      check_val(wb ? "wb_ctrl" : "fill_ctrl", {mem_enable_o, mem_write_o, cpu_stall_o}, {1'b1, wb, 1'b1});
      check_val(wb ? "wb_addr" : "fill_addr", mem_addr_o, la);
      if (wb) check_val("wb_data", mem_data_o, line);
      if (k == dly) begin
        mem_ack_i = 1'b1;
        if (wb) offmem[la] = mem_data_o;
        else mem_data_i = line;
      end
      @(posedge clk);
      #1;
      mem_ack_i = 1'b0;
      mem_data_i = {8{$urandom()}};
    end
  endtask

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wb_dly, input int fill_dly);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic [31:0]      la, va;
    logic [255:0]     new_line;
    bit               hit;
    idx = addr[5 +: IDX_W];
    tg  = addr[31 -: TAG_W];
    la  = {addr[31:5], 5'b0};
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    cpu_req_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_wdata_i = wdata;
    mem_ack_i = 1'b0;
    #1;
    check_val("stall_first", cpu_stall_o, !hit);
    new_line = arch_line(la);
    if (we) new_line[addr[4:2]*32 +: 32] = wdata;
    if (!hit) begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], idx, 5'b0};
        mem_phase(1'b1, va, arch_line(va), wb_dly);
      end
      mem_phase(1'b0, la, mem_line(la), fill_dly);
      @(negedge clk);
      #1;
      check_val("update_ctrl", {cpu_stall_o, mem_enable_o, sram_enable_o, sram_write_o}, 4'b1011);
      check_val("update_line", sram_data_o, new_line);
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = we;
      @(negedge clk);
      #1;
      check_val("stall_retry", cpu_stall_o, 1'b0);
    end else begin
      exp_hits++;
    end
    if (we) begin
      check_val("store_ctrl", {sram_enable_o, sram_write_o, sram_addr_o}, {2'b11, idx});
      check_val("store_line", sram_data_o, new_line);
      arch[addr] = wdata;
      m_dirty[idx] = 1'b1;
    end else begin
      exp_q.push_back(arch_word(addr));
      check_val("load_data", cpu_rdata_o, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
  endtask

  task automatic idle_cycle(input bit stray_ack);
    @(negedge clk);
    mem_ack_i = stray_ack;
    #1;
    check_val("idle_quiet", {cpu_stall_o, mem_enable_o, sram_enable_o}, 3'b000);
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
  endtask

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check_val("hit_cnt", hit_cnt_o, 32'(exp_hits));
    check_val("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif
  endtask

  logic [31:0] conflict;

  initial begin
    for (int s = 0; s < SETS; s++) sram_mem[s] = '0;
    model_reset();
    #2;
    check_all_zero("por");
    apply_reset();

    // directed: fill, store hit, reload, dirty conflict with slow memory
    do_access(1'b0, 32'h100, 32'h0, 0, 0);
    do_access(1'b1, 32'h104, 32'h12345678, 0, 0);
    do_access(1'b0, 32'h104, 32'h0, 0, 0);
    check_val("dirty_set", m_dirty[8 % SETS], 1'b1);
    conflict = 32'h100 + 32'(SETS * 32);
    do_access(1'b0, conflict, 32'h0, 1, 9);
    do_access(1'b0, 32'h104, 32'h0, 2, 0);
    idle_cycle(1'b1);
    check_stats();

    // randomized traffic over a few tags so that conflicts are frequent
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {TAG_W'($urandom_range(0, 3)), IDX_W'($urandom_range(0, SETS - 1)),
           3'($urandom_range(0, 7)), 2'b00};
      do_access(1'($urandom_range(0, 1)), a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end
    check_stats();

    // asynchronous reset in the middle of a refill
    apply_reset();
    @(negedge clk);
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h100;
    @(negedge clk);
    #1;
    check_val("midfill_en", {mem_enable_o, cpu_stall_o}, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midfill_rst", {mem_enable_o, cpu_stall_o, sram_enable_o}, 3'b000);
    model_reset();
    @(negedge clk);
    cpu_req_i = 1'b0;
    rst_n = 1'b1;
    do_access(1'b0, 32'h100, 32'h0, 0, 2);

    // one miss followed by three hits
    apply_reset();
    do_access(1'b0, 32'h200, 32'h0, 0, 1);
    do_access(1'b0, 32'h200, 32'h0, 0, 0);
    do_access(1'b0, 32'h204, 32'h0, 0, 0);
    do_access(1'b0, 32'h208, 32'h0, 0, 0);
    check_val("model_hits", 32'(exp_hits), 32'd3);
    check_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
